// File: rtl/uart_rx_framer.sv
// UART receive framer: 2-flop synchronized rx, mid-bit sampling of start/data/stop,
// single-entry output register with valid/ready handshake, frame-error and overrun pulses.
module uart_rx_framer #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic [BIT_W-1:0]   bit_cnt_r;
  logic [BIT_W-1:0]   bit_cnt_nxt_s;
  logic [WIDTH-1:0]   shift_r;
  logic [WIDTH-1:0]   shift_nxt_s;

  logic               rx_meta_r;
  logic               rxs_r;
  logic               rxs_prev_r;
  logic               fall_s;
  logic               stop_good_s;
  logic               stop_bad_s;

  logic [WIDTH-1:0]   rx_data_r;
  logic [WIDTH-1:0]   rx_data_nxt_s;
  logic               rx_valid_r;
  logic               rx_valid_nxt_s;
  logic               frame_err_r;
  logic               overrun_r;
  logic               overrun_nxt_s;
  logic               busy_r;

  assign fall_s = rxs_prev_r & ~rxs_r;

  // Synchronizer and edge-history flops; all idle-high so reset never fakes a start edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_r  <= 1'b1;
      rxs_r      <= 1'b1;
      rxs_prev_r <= 1'b1;
    end else begin
      rx_meta_r  <= rx;
      rxs_r      <= rx_meta_r;
      rxs_prev_r <= rxs_r;
    end
  end

  // FSM state, bit-period counter, bit counter and shift register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      bit_cnt_r <= {BIT_W{1'b0}};
      shift_r   <= {WIDTH{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      shift_r   <= shift_nxt_s;
    end
  end

  // Next-state logic; stop_good/stop_bad mark the stop-sample cycle
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    bit_cnt_nxt_s = bit_cnt_r;
    shift_nxt_s   = shift_r;
    stop_good_s   = 1'b0;
    stop_bad_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (fall_s) begin
          state_nxt_s = START;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_nxt_s     = {CNT_W{1'b0}};
          bit_cnt_nxt_s = {BIT_W{1'b0}};
          // A start bit that is high again at mid-bit is a glitch
          if (!rxs_r) begin
            state_nxt_s = DATA;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_r == CNT_LAST) begin
          cnt_nxt_s     = {CNT_W{1'b0}};
          shift_nxt_s   = {rxs_r, shift_r[WIDTH-1:1]};
          bit_cnt_nxt_s = bit_cnt_r + BIT_ONE;
          if (bit_cnt_r == BIT_LAST) begin
            state_nxt_s = STOP;
          end else begin
            state_nxt_s = DATA;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_r == CNT_LAST) begin
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = IDLE;
          if (rxs_r) begin
            stop_good_s = 1'b1;
          end else begin
            stop_bad_s = 1'b1;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Output holding register: a same-cycle accept frees the slot for the new word
  always_comb begin
    rx_data_nxt_s  = rx_data_r;
    rx_valid_nxt_s = rx_valid_r;
    overrun_nxt_s  = 1'b0;
    if (stop_good_s) begin
      if (!rx_valid_r || rx_ready) begin
        rx_data_nxt_s  = shift_r;
        rx_valid_nxt_s = 1'b1;
      end else begin
        overrun_nxt_s = 1'b1;
      end
    end else if (rx_valid_r && rx_ready) begin
      rx_valid_nxt_s = 1'b0;
    end else begin
      rx_valid_nxt_s = rx_valid_r;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data_r   <= {WIDTH{1'b0}};
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      rx_data_r   <= rx_data_nxt_s;
      rx_valid_r  <= rx_valid_nxt_s;
      frame_err_r <= stop_bad_s;
      overrun_r   <= overrun_nxt_s;
      busy_r      <= (state_nxt_s != IDLE);
    end
  end

  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard bench for uart_rx_framer: stimulus pushes expected events, a negedge
// monitor pops and compares whenever a word, frame error or overrun appears.
`timescale 1ns/1ps
module tb_uart_rx_framer;
  localparam int W   = 8;
  localparam int CPB = 16;

  localparam logic [1:0] K_WORD = 2'd0;
  localparam logic [1:0] K_ERR  = 2'd1;
  localparam logic [1:0] K_OVR  = 2'd2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         rx = 1'b1;
  logic         rx_ready = 1'b0;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         frame_err;
  logic         overrun;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;
  logic prev_valid = 1'b0;
  logic prev_accept = 1'b0;
  logic [9:0] exp_q[$];

  uart_rx_framer #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_event(input logic [1:0] kind, input logic [7:0] data);
    logic [9:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: actual kind=%0d data=%0h required none", kind, data);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", {30'd0, kind}, {30'd0, e[9:8]});
      if (kind == K_WORD) check("rx_data", {24'd0, data}, {24'd0, e[7:0]});
    end
  endtask

  // Monitor: a word is presented when rx_valid rises or reloads after an accept
  always @(negedge clk) begin
    if (!reset) begin
      prev_valid  <= 1'b0;
      prev_accept <= 1'b0;
    end else begin
      if (rx_valid) valid_cycles <= valid_cycles + 1;
      if (rx_valid && (!prev_valid || prev_accept)) expect_event(K_WORD, rx_data);
      if (frame_err) expect_event(K_ERR, 8'h00);
      if (overrun) expect_event(K_OVR, 8'h00);
      prev_valid  <= rx_valid;
      prev_accept <= rx_valid && rx_ready;
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(posedge clk); #1 rx = 1'b0;
    for (int i = 0; i < W; i++) begin
      repeat (CPB) @(posedge clk);
      #1 rx = d[i];
    end
    repeat (CPB) @(posedge clk); #1 rx = stop;
    repeat (CPB) @(posedge clk); #1 rx = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
    check({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
    check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int v0;
    logic [7:0] part;
    repeat (3) @(posedge clk);
    #2 check_all_zero("reset");
    @(posedge clk); #1 reset = 1'b1;
    repeat (5) @(posedge clk);

    // Good frame with consumer always ready: one-cycle valid
    #1 rx_ready = 1'b1;
    v0 = valid_cycles;
    exp_q.push_back({K_WORD, 8'hA5});
    send_frame(8'hA5, 1'b1);
    repeat (20) @(posedge clk);
    #2 check("a5_valid_cycles", valid_cycles - v0, 32'd1);

    // Short low glitch: busy through START only, no output events
    @(posedge clk); #1 rx = 1'b0;
    repeat (4) @(posedge clk); #1 rx = 1'b1;
    repeat (2) @(posedge clk); #2 check("glitch_busy_high", {31'd0, busy}, 32'd1);
    repeat (8) @(posedge clk); #2 check("glitch_busy_low", {31'd0, busy}, 32'd0);
    repeat (10) @(posedge clk);

    // Bad stop bit, then a good frame
    exp_q.push_back({K_ERR, 8'h00});
    send_frame(8'h3C, 1'b0);
    repeat (4) @(posedge clk);
    #2 check("ferr_no_valid", {31'd0, rx_valid}, 32'd0);
    exp_q.push_back({K_WORD, 8'h11});
    send_frame(8'h11, 1'b1);
    repeat (4) @(posedge clk);

    // Two frames with consumer stalled: second overruns
    #1 rx_ready = 1'b0;
    exp_q.push_back({K_WORD, 8'h12});
    exp_q.push_back({K_OVR, 8'h00});
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    repeat (4) @(posedge clk);
    #2 check("ovr_valid_held", {31'd0, rx_valid}, 32'd1);
    check("ovr_data_kept", {24'd0, rx_data}, 32'h12);
    @(posedge clk); #1 rx_ready = 1'b1;
    @(posedge clk); #1 rx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 check("accept_clears_valid", {31'd0, rx_valid}, 32'd0);

    // Accept on the exact completion cycle of the next frame
    exp_q.push_back({K_WORD, 8'h55});
    send_frame(8'h55, 1'b1);
    repeat (4) @(posedge clk);
    exp_q.push_back({K_WORD, 8'h66});
    fork
      send_frame(8'h66, 1'b1);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk); #1 rx_ready = 1'b0;
      end
    join
    repeat (4) @(posedge clk);
    #2 check("same_cycle_valid", {31'd0, rx_valid}, 32'd1);
    check("same_cycle_data", {24'd0, rx_data}, 32'h66);

    // Reset in the middle of data bit 4
    part = 8'hC3;
    @(posedge clk); #1 rx = 1'b0;
    for (int i = 0; i < 5; i++) begin
      repeat (CPB) @(posedge clk);
      #1 rx = part[i];
    end
    repeat (8) @(posedge clk);
    #1 check("busy_before_reset", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    rx = 1'b1;
    #1 check_all_zero("midreset");
    repeat (3) @(posedge clk); #1 reset = 1'b1;
    repeat (5) @(posedge clk);
    #1 rx_ready = 1'b1;
    exp_q.push_back({K_WORD, 8'hF0});
    send_frame(8'hF0, 1'b1);
    repeat (10) @(posedge clk);

    #2 check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 Parameter WIDTH, default 8: data bits per frame; legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 868: clk cycles per bit period; legal range >= 4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 rx  input  1  asynchronous serial line; idle high.
REQ-006 rx_data  output  WIDTH  received data word, first-received bit in bit 0.
REQ-007 rx_valid  output  1  rx_data holds an unconsumed word.
REQ-008 rx_ready  input  1  consumer accepts rx_data this cycle.
REQ-009 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 overrun  output  1  one-cycle pulse: completed word dropped because rx_valid was still pending.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; both flops reset to 1; all logic uses the synchronized value (rxs).
REQ-013 Falling edge SHALL be defined as previous rxs = 1 and current rxs = 0.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP; the FSM resets to IDLE.
REQ-015 IDLE: on a falling edge, go to START and clear the bit-period counter; otherwise stay in IDLE.
REQ-016 START: count to CLKS_PER_BIT/2 - 1 (integer division); sample rxs at the terminal count.
REQ-017 START sample = 0: go to DATA. START sample = 1: go to IDLE and treat the edge as a glitch (no output activity).
REQ-018 DATA: sample rxs once every CLKS_PER_BIT cycles after the start-bit sample, i.e. at mid-bit.
REQ-019 DATA: each sample shifts into an internal WIDTH-bit register, LSB first, and a bit counter increments; after the WIDTH-th sample, go to STOP.
REQ-020 STOP: sample rxs CLKS_PER_BIT cycles after the last data sample, then return to IDLE on the next cycle.
REQ-021 Stop sample = 1 (good frame): in the following cycle, assert rx_valid and load rx_data from the shift register, unless REQ-024 applies.
REQ-022 Stop sample = 0: pulse frame_err for exactly one cycle; rx_data and rx_valid unchanged; the word is discarded.
REQ-023 rx_valid SHALL stay high and rx_data SHALL stay stable until a cycle with rx_valid && rx_ready; rx_valid clears in the following cycle.
REQ-024 Good frame completes while rx_valid = 1 and rx_ready = 0 in that cycle: pulse overrun for one cycle, drop the new word, retain the old rx_data.
REQ-025 Good frame completes in the same cycle as an accept (rx_valid && rx_ready): load the new word; rx_valid remains high; no overrun.
REQ-026 rx_ready while rx_valid = 0 SHALL have no effect.
REQ-027 After a frame error, IDLE requires a fresh falling edge, so a held-low line (break) SHALL NOT retrigger reception.
REQ-028 A falling edge during START, DATA or STOP SHALL be ignored (no resynchronization mid-frame).
REQ-029 Counters SHALL be sized to hold CLKS_PER_BIT-1 and WIDTH respectively, with no wrap within a frame.
REQ-030 The good-frame path SHALL take the shortest latency set by REQ-012..REQ-021: rx_valid rises 2 (sync) + CLKS_PER_BIT/2 + (WIDTH+1)*CLKS_PER_BIT + 1..2 cycles after the rx falling edge, with the exact value fixed in the implementation notes and kept constant.

Reset
REQ-031 While reset = 0, outputs SHALL be: rx_data = 0, rx_valid = 0, frame_err = 0, overrun = 0, busy = 0; FSM in IDLE, counters 0, synchronizer flops 1.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no partial word emitted; reception resumes at the first falling edge after release.

Verification (CLKS_PER_BIT = 16, WIDTH = 8)
REQ-033 Frame 0xA5 with stop = 1 and rx_ready held 1 -> rx_valid high for exactly 1 cycle, rx_data = 0xA5, frame_err = 0, overrun = 0.
REQ-034 rx low for 4 clocks then high -> busy high until the START sample, then back to IDLE; rx_valid, frame_err and overrun stay 0.
REQ-035 Frame 0x3C with stop = 0 -> one frame_err pulse, rx_valid stays 0; a following good 0x11 frame -> rx_data = 0x11.
REQ-036 Frames 0x12 then 0x34 back-to-back, rx_ready = 0 -> rx_valid = 1 with rx_data = 0x12, one overrun pulse at the end of the 0x34 frame; raising rx_ready -> 0x12 accepted, then rx_valid = 0.
REQ-037 0x55 pending with rx_ready asserted on the exact completion cycle of 0x66 -> rx_data = 0x66, rx_valid stays 1, no overrun.
REQ-038 reset driven low during data bit 4 of a frame -> all outputs 0 and busy = 0; after release, frame 0xF0 -> rx_data = 0xF0.
